// File: rtl/matrix_loader.sv
// matrix_loader
//   Upstream feeder for the MPU memory. Collects N*N matrix elements (N = 1..DIM)
//   one element per transfer over a valid/ready stream, packs them row-major into
//   a DIM x DIM x ELEM_W word (unused rows/columns are zero) and writes operand A
//   to base_addr and operand B to base_addr+1 (address wraps). A one-cycle done
//   pulse follows the write of B.
//
// Ports
//   clock       in   system clock, all logic on posedge
//   reset       in   synchronous active-high reset
//   start_load  in   begin loading A then B (honoured only when idle)
//   size        in   active dimension N, sampled with an accepted start_load
//   base_addr   in   address for A, sampled with size
//   in_valid    in   element present on in_data
//   in_data     in   element, row-major order
//   in_ready    out  high only while collecting elements
//   mem_addr    out  memory address
//   mem_data    out  packed word (meaningful while mem_wren=1)
//   mem_wren    out  memory write enable, one cycle per matrix
//   busy        out  high whenever not idle
//   done        out  one-cycle pulse after B has been written
//   err_size    out  one-cycle pulse for a start_load with an out-of-range size
module matrix_loader #(
  parameter int ELEM_W = 8,
  parameter int DIM    = 5,
  parameter int ADDR_W = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start_load,
  input  logic [2:0]                size,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic                      in_valid,
  input  logic [ELEM_W-1:0]         in_data,
  output logic                      in_ready,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [ELEM_W*DIM*DIM-1:0] mem_data,
  output logic                      mem_wren,
  output logic                      busy,
  output logic                      done,
  output logic                      err_size
);

  localparam int NELEM  = DIM * DIM;
  localparam int WORD_W = ELEM_W * NELEM;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_WRITE,
    S_DONE
  } state_t;

  state_t              state;
  logic [WORD_W-1:0]   buffer;
  logic [2:0]          row;
  logic [2:0]          col;
  logic [2:0]          n_m1;
  logic [ADDR_W-1:0]   base_q;
  logic                mat_idx;
  logic [NELEM-1:0]    elem_sel;
  logic                size_ok;
  logic                transfer;

  // The buffer is a register, so driving the memory word straight from it keeps
  // mem_data a registered output; it holds the complete matrix during WRITE.
  assign mem_data = buffer;

  assign size_ok  = (size != 3'd0) && (32'(size) <= DIM);
  assign transfer = in_valid && in_ready;

  // One-hot select of the buffer slot addressed by the current row/column.
  always_comb begin
    elem_sel = '0;
    for (int unsigned r = 0; r < DIM; r++) begin
      for (int unsigned c = 0; c < DIM; c++) begin
        elem_sel[r*DIM + c] = (row == 3'(r)) && (col == 3'(c));
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      buffer   <= '0;
      row      <= '0;
      col      <= '0;
      n_m1     <= '0;
      base_q   <= '0;
      mat_idx  <= 1'b0;
      in_ready <= 1'b0;
      mem_addr <= '0;
      mem_wren <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_size <= 1'b0;
    end else begin
      mem_wren <= 1'b0;
      done     <= 1'b0;
      err_size <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start_load) begin
            if (size_ok) begin
              n_m1     <= size - 3'd1;
              base_q   <= base_addr;
              buffer   <= '0;
              row      <= '0;
              col      <= '0;
              mat_idx  <= 1'b0;
              in_ready <= 1'b1;
              busy     <= 1'b1;
              state    <= S_FILL;
            end else begin
              err_size <= 1'b1;
            end
          end
        end

        S_FILL: begin
          if (transfer) begin
            for (int unsigned k = 0; k < NELEM; k++) begin
              if (elem_sel[k]) begin
                buffer[k*ELEM_W +: ELEM_W] <= in_data;
              end
            end
            if (col == n_m1) begin
              col <= '0;
              if (row == n_m1) begin
                // Last element: the write is issued on the very next cycle.
                in_ready <= 1'b0;
                mem_wren <= 1'b1;
                mem_addr <= base_q + ADDR_W'(mat_idx);
                state    <= S_WRITE;
              end else begin
                row <= row + 3'd1;
              end
            end else begin
              col <= col + 3'd1;
            end
          end
        end

        S_WRITE: begin
          if (!mat_idx) begin
            mat_idx  <= 1'b1;
            buffer   <= '0;
            row      <= '0;
            col      <= '0;
            in_ready <= 1'b1;
            state    <= S_FILL;
          end else begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
